// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard controller: bubbles, freeze and flush arbitration.
// In: MemRead_i/INS_11_7_i (EX load), RD1/RD2 addr+use (ID), MemStall_i, Flush_i.
// Out: PCWrite_o, Stall_o, No_op_o, Freeze_o, Flush_o, StallCnt_o.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int ZERO_GUARD      = 1,
    parameter int STALL_CNT_W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   MemRead_i,
    input  logic [REG_ADDR_W-1:0]  INS_11_7_i,
    input  logic [REG_ADDR_W-1:0]  RD1addr_i,
    input  logic [REG_ADDR_W-1:0]  RD2addr_i,
    input  logic                   RS1use_i,
    input  logic                   RS2use_i,
    input  logic                   MemStall_i,
    input  logic                   Flush_i,
    output logic                   PCWrite_o,
    output logic                   Stall_o,
    output logic                   No_op_o,
    output logic                   Freeze_o,
    output logic                   Flush_o,
    output logic [STALL_CNT_W-1:0] StallCnt_o
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // The hit cycle itself is the first bubble, HOLD covers the rest.
    localparam logic [2:0] REM_INIT =
        (LOAD_USE_STALLS > 1) ? 3'(LOAD_USE_STALLS - 2) : 3'd0;
    localparam bit MULTI = (LOAD_USE_STALLS > 1);

    state_t                 state_q;
    logic [2:0]             rem_q;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic rs1_hit;
    logic rs2_hit;
    logic rd_zero;
    logic hit;
    logic bubble;

    assign rs1_hit = RS1use_i && (INS_11_7_i == RD1addr_i);
    assign rs2_hit = RS2use_i && (INS_11_7_i == RD2addr_i);
    assign rd_zero = (ZERO_GUARD != 0) && (INS_11_7_i == '0);
    assign hit     = MemRead_i && (rs1_hit || rs2_hit) && !rd_zero;

    // HOLD keeps bubbling whatever the ID stage now holds.
    assign bubble  = (state_q == HOLD) || hit;

    always_comb begin
        PCWrite_o = 1'b0;
        Stall_o   = 1'b0;
        No_op_o   = 1'b0;
        Freeze_o  = 1'b0;
        Flush_o   = 1'b0;
        if (!rst_i) begin
            PCWrite_o = 1'b0;
        end else if (MemStall_i) begin
            Freeze_o = 1'b1;
            Stall_o  = 1'b1;
        end else if (bubble) begin
            Stall_o = 1'b1;
            No_op_o = 1'b1;
        end else begin
            PCWrite_o = 1'b1;
            Flush_o   = Flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= 3'd0;
        end else if (!MemStall_i) begin
            unique case (state_q)
                IDLE: begin
                    if (hit && MULTI) begin
                        state_q <= HOLD;
                        rem_q   <= REM_INIT;
                    end
                end
                HOLD: begin
                    if (rem_q == 3'd0) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rem_q   <= 3'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (!PCWrite_o && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    assign StallCnt_o = cnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised load-use hazard controller for the 5-stage RISC-V pipeline, sitting between the ID stage and the IF/ID, ID/EX and PC write enables. It detects load-use hazards against the EX-stage load and holds the pipeline for a configurable number of bubble cycles. It arbitrates that stall against a whole-pipeline data-memory freeze and a branch flush request. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_USE_STALLS, 1, total bubble cycles per load-use hazard (legal 1..7).
- ZERO_GUARD, 1, when 1 a destination of register 0 never raises a hazard.
- STALL_CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- MemRead_i  in  1  EX-stage instruction is a load.
- INS_11_7_i  in  REG_ADDR_W  EX-stage destination register.
- RD1addr_i  in  REG_ADDR_W  ID-stage rs1.
- RD2addr_i  in  REG_ADDR_W  ID-stage rs2.
- RS1use_i  in  1  ID instruction reads rs1.
- RS2use_i  in  1  ID instruction reads rs2.
- MemStall_i  in  1  data memory busy; whole pipeline must hold.
- Flush_i  in  1  branch taken in ID; flush request for IF/ID.
- PCWrite_o  out  1  PC write enable.
- Stall_o  out  1  hold IF/ID register.
- No_op_o  out  1  insert bubble into ID/EX.
- Freeze_o  out  1  hold every pipeline register (EX/MEM, MEM/WB included).
- Flush_o  out  1  qualified IF/ID flush.
- StallCnt_o  out  STALL_CNT_W  saturating count of cycles with PCWrite_o=0.

## Operation
- hit = MemRead_i & ((RS1use_i & INS_11_7_i==RD1addr_i) | (RS2use_i & INS_11_7_i==RD2addr_i)) & ~(ZERO_GUARD & INS_11_7_i==0).
- States: IDLE, HOLD. Remaining-bubble counter rem is 3 bits.
- Priority per cycle: reset > freeze > load-use > flush > run.
- Freeze (MemStall_i=1, any state): Freeze_o=1, PCWrite_o=0, Stall_o=1, No_op_o=0, Flush_o=0. State and rem are unchanged. hit is not acted on.
- IDLE with hit and no freeze: PCWrite_o=0, Stall_o=1, No_op_o=1, Flush_o=0.
  - If LOAD_USE_STALLS>1: next state HOLD, rem=LOAD_USE_STALLS-2.
  - Otherwise remain IDLE.
- HOLD, no freeze: same outputs as a hit cycle, regardless of current hit.
  - rem==0: next state IDLE.
  - Otherwise rem decrements.
- IDLE, no hit, no freeze: PCWrite_o=1, Stall_o=0, No_op_o=0, Freeze_o=0, Flush_o=Flush_i.
- Flush_i during a load-use stall or freeze is dropped (Flush_o=0). The branch stays in ID and re-asserts Flush_i when the stall ends.
- StallCnt_o increments by 1 on each clock edge where PCWrite_o=0 and rst_i=1. It saturates at all-ones and never wraps.

## Timing
- All outputs except StallCnt_o are combinational from inputs and state. A first hazard cycle asserts in the same cycle hit rises (zero latency).
- One hazard gives exactly LOAD_USE_STALLS consecutive non-freeze cycles with No_op_o=1. Freeze cycles interleaved inside the sequence stretch it but do not consume bubbles.
- A hit in the last HOLD cycle is ignored. A hit in the following IDLE cycle starts a new sequence.
- Reset asserted, asynchronously: state IDLE, rem=0, StallCnt_o=0.
  - While rst_i=0, outputs are forced: PCWrite_o=0, Stall_o=0, No_op_o=0, Freeze_o=0, Flush_o=0.
  - Reset mid-HOLD abandons the sequence. The first cycle after release is IDLE.
- Reset release: normal operation from the first rising edge with rst_i=1.

## Test plan
- LOAD_USE_STALLS=1: MemRead_i=1, INS_11_7_i=5, RD1addr_i=5, RS1use_i=1 for one cycle -> that cycle PCWrite_o=0, Stall_o=1, No_op_o=1. Next cycle (MemRead_i=0) all idle; StallCnt_o=1.
- LOAD_USE_STALLS=3: same hit for one cycle -> No_op_o=1 for exactly 3 cycles, then PCWrite_o=1; StallCnt_o=3.
- ZERO_GUARD=1: MemRead_i=1, INS_11_7_i=0, RD2addr_i=0, RS2use_i=1 -> no stall. Also rd=7, RD2addr_i=7, RS2use_i=0 -> no stall.
- LOAD_USE_STALLS=2, MemStall_i=1 for 2 cycles inserted after the first bubble -> Freeze_o=1, No_op_o=0 for those 2 cycles. Exactly one more bubble follows; StallCnt_o=4.
- Flush_i=1 with hit=1 -> Flush_o=0. Flush_i=1 in IDLE without hit -> Flush_o=1, PCWrite_o=1.
- Reset: assert rst_i=0 mid-HOLD (LOAD_USE_STALLS=4, second bubble) -> all outputs 0 and StallCnt_o=0 immediately. After release with no hit -> PCWrite_o=1. Separately, force StallCnt_o saturation with STALL_CNT_W=2 -> holds at 3.
